// File: rtl/mem_port_arbiter.sv
// N-channel access arbiter in front of a single-port synchronous RAM.
// It issues at most one access per cycle. Arbitration is either fixed priority
// or round-robin, and a channel can lock the arbiter for a burst. Read data is
// returned to the requesting channel RD_LAT+1 cycles after its grant cycle.
// The RAM must present ram_q_i RD_LAT cycles after the grant cycle, and the
// arbiter registers it at the following edge.
module mem_port_arbiter #(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH-1:0]          we_i,
  input  logic [N_CH-1:0]          lock_i,
  input  logic [N_CH*ADDR_W-1:0]   addr_i,
  input  logic [N_CH*DATA_W-1:0]   wdata_i,
  output logic [N_CH-1:0]          gnt_o,
  output logic [N_CH-1:0]          rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ADDR_W-1:0]        ram_addr_o,
  output logic [DATA_W-1:0]        ram_wdata_o,
  output logic                     ram_wren_o,
  output logic                     ram_rden_o,
  input  logic [DATA_W-1:0]        ram_q_i,
  output logic                     locked_o
);

  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // state   | meaning
  // ST_ARB  | normal arbitration between all requesting channels
  // ST_LOCK | only owner_q may be granted, until it accepts with lock low
  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    sel_id;
  logic               sel_vld;
  logic               sel_we;
  logic               sel_lock;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic [ADDR_W-1:0]  ram_addr_q;
  logic [DATA_W-1:0]  ram_wdata_q;
  logic               ram_wren_q;
  logic               ram_rden_q;
  logic [N_CH-1:0]    rvalid_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               locked_q;

  // Read tags travel alongside the RAM pipeline; the last stage feeds rvalid.
  logic [RD_LAT-1:0]  tag_vld_q;
  logic [ID_W-1:0]    tag_id_q [RD_LAT];

  // Pick the winning channel: the lock owner, the lowest index, or the first from rr_ptr.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    cand    = '0;
    if (state_q == ST_LOCK) begin
      sel_vld = req_i[owner_q];
      sel_id  = owner_q;
    end else if (ARB_MODE == 0) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        cand = ID_W'(i);
        if (req_i[cand]) begin
          sel_vld = 1'b1;
          sel_id  = cand;
        end
      end
    end else begin
      for (int off = N_CH - 1; off >= 0; off--) begin
        cand = ID_W'((int'(rr_ptr_q) + off) % N_CH);
        if (req_i[cand]) begin
          sel_vld = 1'b1;
          sel_id  = cand;
        end
      end
    end
    gnt_o = '0;
    if (sel_vld && !rst_i) gnt_o[sel_id] = 1'b1;
  end

  // Route the winning channel's command fields.
  always_comb begin
    sel_we    = we_i[sel_id];
    sel_lock  = lock_i[sel_id];
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next FSM state, lock owner and round-robin pointer.
  // rr_ptr follows every accept, so it naturally equals owner+1 on lock exit.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (sel_vld) begin
      rr_ptr_d = (int'(sel_id) == N_CH - 1) ? '0 : sel_id + 1'b1;
      if (state_q == ST_ARB) begin
        if (sel_lock) begin
          state_d = ST_LOCK;
          owner_d = sel_id;
        end
      end else if (!sel_lock) begin
        state_d = ST_ARB;
        owner_d = '0;
      end
    end
  end

  // FSM registers, RAM command issue, read tag pipeline and read-data return.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_ARB;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      locked_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wren_q  <= 1'b0;
      ram_rden_q  <= 1'b0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      tag_vld_q   <= '0;
      for (int s = 0; s < RD_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= (state_d == ST_LOCK);
      ram_wren_q <= sel_vld & sel_we;
      ram_rden_q <= sel_vld & ~sel_we;
      if (sel_vld) begin
        ram_addr_q  <= sel_addr;
        ram_wdata_q <= sel_wdata;
      end
      tag_vld_q[0] <= sel_vld & ~sel_we;
      tag_id_q[0]  <= sel_id;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      rvalid_q <= '0;
      if (tag_vld_q[RD_LAT-1]) begin
        rvalid_q[tag_id_q[RD_LAT-1]] <= 1'b1;
        rdata_q                      <= ram_q_i;
      end
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_wren_o  = ram_wren_q;
  assign ram_rden_o  = ram_rden_q;
  assign locked_o    = locked_q;

endmodule
